wave_gen: RTL and testbench
===========================

Name: wave_gen

Overview:
- Phase-accumulator waveform generator in the FPGA client.
- Sits directly downstream of the variable-rate clock divider. Consumes its rate as a single-cycle step strobe in the system clock domain, and never uses a divided clock as a clock.
- Produces one sample per step on a valid/ready stream toward the SPI/DAC output stage.
- Waveforms: square, sawtooth, triangle, midscale DC.

Parameters:
- DATA_W, 8, sample width in bits.
- PHASE_W, 8, phase accumulator width. Must satisfy PHASE_W >= DATA_W.

Ports:
- clk  input  1  system clock, rising edge only.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  run control; low forces the idle state.
- step_en  input  1  one-cycle rate strobe from the divider stage.
- wave_sel  input  2  00 square, 01 sawtooth, 10 triangle, 11 DC.
- phase_inc  input  PHASE_W  phase increment per step.
- sample  output  DATA_W  current sample.
- sample_valid  output  1  sample holds unconsumed data.
- sample_ready  input  1  downstream accepts sample this cycle.
- cycle_done  output  1  one-cycle pulse when the phase wraps.
- overrun  output  1  sticky: a step replaced an unaccepted sample.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE, phase = 0, sample = 0, sample_valid = 0, cycle_done = 0, overrun = 0.
- FSM states: IDLE, PRIME, RUN.
  - IDLE: phase held at 0, sample_valid = 0, overrun = 0, step_en ignored. Goes to PRIME when enable = 1.
  - PRIME: lasts one cycle. Loads the phase-0 sample for the current wave_sel and sets sample_valid. Goes to RUN, or to IDLE if enable = 0.
  - RUN: on step_en, phase <= (phase + phase_inc) mod 2^PHASE_W. Next cycle, sample <= f(new phase) and sample_valid = 1. Goes to IDLE when enable = 0.
- Step-to-sample latency: exactly 1 cycle.
- Leaving RUN/PRIME for IDLE: completes on the cycle after enable falls. Clears phase, sample_valid and overrun. sample itself holds its last value.
- wave_sel and phase_inc are sampled only at PRIME or at a step_en cycle. Changing them between steps has no effect until the next step.
- cycle_done: pulses for 1 cycle, aligned with sample_valid rising for the sample whose addition carried out of bit PHASE_W-1.
- Waveform rules. Let P = phase[PHASE_W-1 -: DATA_W] (top DATA_W bits of phase).
  - Square: all ones if phase MSB = 1, else 0.
  - Sawtooth: P.
  - Triangle: let T = {P[DATA_W-2:0], 1'b0}. Output T if phase MSB = 0, else ~T.
  - DC: 2^(DATA_W-1).
- Handshake:
  - A transfer occurs when sample_valid && sample_ready.
  - After a transfer with no new step, sample_valid drops the next cycle.
  - While sample_valid && !sample_ready, sample is held stable.
- Simultaneous events:
  - step_en while sample_valid && !sample_ready: the phase still advances, the new sample overwrites the old one, and overrun is set.
  - step_en in the same cycle as a transfer: no overrun, and sample_valid stays 1 with the new sample.
  - step_en during PRIME: ignored.
- overrun clears only in IDLE or on reset.
- Phase wrap: natural modulo. phase_inc = 0 gives a constant sample, emitted on every step.
- Reset mid-operation: immediate return to the reset values. After reset releases with enable high, the FSM enters PRIME on the first clock edge.

Test Plan:
- Sawtooth, phase_inc = 16: reset, then enable = 1, then 17 step_en pulses each 4 cycles apart, sample_ready = 1. Required: samples 0 (PRIME), then 16, 32, …, 240, then 0. cycle_done pulses only with the final 0.
- Triangle, phase_inc = 64, four steps. Required: after PRIME 0, samples 128, 255, 127, 0, with cycle_done on the last.
- Square, phase_inc = 128, DC check: steps give 255, 0, 255. Then switch wave_sel to 11 mid-run and step once: sample 128, but only on the step, not at the moment of the switch.
- Backpressure: sample_ready = 0, sawtooth, phase_inc = 16, two steps. sample holds 16 after the first. The second step gives sample 32 and overrun = 1. Raising ready gives a single transfer and sample_valid drops. overrun stays 1 until enable = 0.
- Step coincident with transfer: valid sample present, ready = 1 and step_en in the same cycle. Required: no overrun, sample_valid stays 1, new value appears next cycle.
- Async reset: assert rst_n = 0 mid-cycle during RUN. Outputs go to 0 immediately without waiting for a clock edge. After release with enable = 1, the first sample is the phase-0 value.

Source files
------------

// File: rtl/wave_gen.sv
// Phase-accumulator waveform generator.
// A one-cycle step strobe from the clock divider advances the phase, and
// the resulting sample is offered on a valid/ready stream one cycle later.
// Available waveforms: square, sawtooth, triangle and midscale DC.
module wave_gen #(
  parameter int DATA_W  = 8,
  parameter int PHASE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               step_en,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] phase_inc,
  output logic [DATA_W-1:0]  sample,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               cycle_done,
  output logic               overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                cycle_done_q, cycle_done_d;
  logic                overrun_q, overrun_d;

  // The extra top bit catches the carry out of the accumulator; that carry marks a wrap.
  logic [PHASE_W:0]    sum_s;

  // Maps a phase value to a sample for the selected waveform.
  // All shapes are built from the top DATA_W bits of the phase.
  function automatic logic [DATA_W-1:0] wave_fn(input logic [PHASE_W-1:0] ph,
                                                 input logic [1:0]         sel);
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] t;
    p = ph[PHASE_W-1 -: DATA_W];
    // The triangle rises over the first half-period at twice the sawtooth slope.
    // It falls over the second half as the mirror image.
    t = {p[DATA_W-2:0], 1'b0};
    case (sel)
      2'b00:   wave_fn = {DATA_W{ph[PHASE_W-1]}};
      2'b01:   wave_fn = p;
      2'b10:   wave_fn = ph[PHASE_W-1] ? ~t : t;
      2'b11:   wave_fn = {1'b1, {(DATA_W-1){1'b0}}};
      default: wave_fn = {DATA_W{1'b0}};
    endcase
  endfunction

  assign sum_s = {1'b0, phase_q} + {1'b0, phase_inc};

  // Next-state logic: FSM transitions, phase advance, sample load and handshake.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    sample_d     = sample_q;
    valid_d      = valid_q;
    cycle_done_d = 1'b0;
    overrun_d    = overrun_q;
    case (state_q)
      IDLE: begin
        // Step strobes are ignored here; only enable can move the FSM out of IDLE.
        phase_d   = {PHASE_W{1'b0}};
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        if (enable) begin
          state_d = PRIME;
        end else begin
          state_d = IDLE;
        end
      end
      PRIME: begin
        if (!enable) begin
          state_d   = IDLE;
          phase_d   = {PHASE_W{1'b0}};
          valid_d   = 1'b0;
          overrun_d = 1'b0;
        end else begin
          // Offer the phase-0 sample so the consumer sees data before the first step.
          // Any step strobe that lands in this cycle is dropped.
          state_d  = RUN;
          phase_d  = {PHASE_W{1'b0}};
          sample_d = wave_fn({PHASE_W{1'b0}}, wave_sel);
          valid_d  = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          // sample keeps its last value; only the stream state is cleared.
          state_d   = IDLE;
          phase_d   = {PHASE_W{1'b0}};
          valid_d   = 1'b0;
          overrun_d = 1'b0;
        end else if (step_en) begin
          state_d      = RUN;
          phase_d      = sum_s[PHASE_W-1:0];
          sample_d     = wave_fn(sum_s[PHASE_W-1:0], wave_sel);
          valid_d      = 1'b1;
          cycle_done_d = sum_s[PHASE_W];
          // A step in the same cycle as a transfer is not an overrun.
          // Only replacing a sample that was never accepted counts.
          if (valid_q && !sample_ready) begin
            overrun_d = 1'b1;
          end else begin
            overrun_d = overrun_q;
          end
        end else if (valid_q && sample_ready) begin
          state_d = RUN;
          valid_d = 1'b0;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d   = IDLE;
        phase_d   = {PHASE_W{1'b0}};
        valid_d   = 1'b0;
        overrun_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= {PHASE_W{1'b0}};
      sample_q     <= {DATA_W{1'b0}};
      valid_q      <= 1'b0;
      cycle_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      cycle_done_q <= cycle_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign cycle_done   = cycle_done_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_wave_gen.sv
// Self-checking bench for wave_gen.
// Each prime or step pushes its expected sample, wrap and overrun bits to a scoreboard queue.
// The entry is popped and compared once the DUT has registered the result.
module tb_wave_gen;

  localparam int DW = 8;
  localparam int PW = 8;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          step_en;
  logic [1:0]    wave_sel;
  logic [PW-1:0] phase_inc;
  logic [DW-1:0] sample;
  logic          sample_valid;
  logic          sample_ready;
  logic          cycle_done;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  // Bench-side model of the generator.
  int model_phase  = 0;
  int model_sample = 0;
  bit model_valid  = 1'b0;
  bit model_ovr    = 1'b0;
  int exp_q[$];

  wave_gen #(.DATA_W(DW), .PHASE_W(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .step_en      (step_en),
    .wave_sel     (wave_sel),
    .phase_inc    (phase_inc),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .cycle_done   (cycle_done),
    .overrun      (overrun)
  );

  // 10-unit system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference waveform computed arithmetically from the phase
  function automatic int model_wave(input int ph, input logic [1:0] sel);
    int p;
    p = ph >> (PW - DW);
    case (sel)
      2'b00:   return (ph >= (1 << (PW - 1))) ? ((1 << DW) - 1) : 0;
      2'b01:   return p;
      2'b10:   return (p < (1 << (DW - 1))) ? (2 * p) : (((1 << DW) - 1) - 2 * (p - (1 << (DW - 1))));
      default: return 1 << (DW - 1);
    endcase
  endfunction

  // Pop one scoreboard entry and compare it with the DUT outputs
  task automatic pop_check(input string tag);
    int e;
    if (exp_q.size() == 0) begin
      check({tag, ":sb_underflow"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, ":sample"}, sample, e & 255);
      check({tag, ":valid"}, sample_valid, 32'd1);
      check({tag, ":cycle_done"}, cycle_done, (e >> 8) & 1);
      check({tag, ":overrun"}, overrun, (e >> 9) & 1);
    end
  endtask

  // Idle cycle: no step; the model applies any transfer, then holds are checked
  task automatic tick(input string tag);
    if (model_valid && sample_ready) model_valid = 1'b0;
    @(negedge clk);
    check({tag, ":valid"}, sample_valid, 32'(model_valid));
    check({tag, ":sample"}, sample, 32'(model_sample));
    check({tag, ":cycle_done"}, cycle_done, 32'd0);
    check({tag, ":overrun"}, overrun, 32'(model_ovr));
  endtask

  // Release reset and raise enable, then expect the phase-0 sample two edges later
  task automatic prime(input string tag);
    rst_n  = 1'b1;
    enable = 1'b1;
    step_en = 1'b1;  // must be ignored on the IDLE->PRIME and PRIME->RUN edges
    @(negedge clk);
    check({tag, ":prime_valid"}, sample_valid, 32'd0);
    model_phase  = 0;
    model_sample = model_wave(0, wave_sel);
    model_valid  = 1'b1;
    exp_q.push_back(model_sample);
    @(negedge clk);
    step_en = 1'b0;
    pop_check(tag);
  endtask

  task automatic do_step(input string tag);
    int sum;
    int cd;
    sum = model_phase + int'(phase_inc);
    cd = (sum >= (1 << PW)) ? 1 : 0;
    model_phase  = sum % (1 << PW);
    model_sample = model_wave(model_phase, wave_sel);
    if (model_valid && !sample_ready) model_ovr = 1'b1;
    model_valid = 1'b1;
    exp_q.push_back((int'(model_ovr) << 9) | (cd << 8) | model_sample);
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    pop_check(tag);
  endtask

  // Drop enable; one edge later the stream state is cleared and sample holds
  task automatic disable_gen(input string tag);
    enable = 1'b0;
    @(negedge clk);
    model_phase = 0;
    model_valid = 1'b0;
    model_ovr   = 1'b0;
    check({tag, ":idle_valid"}, sample_valid, 32'd0);
    check({tag, ":idle_overrun"}, overrun, 32'd0);
    check({tag, ":idle_sample_hold"}, sample, 32'(model_sample));
    tick({tag, ":idle"});
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    step_en      = 1'b0;
    wave_sel     = 2'b01;
    phase_inc    = 8'd16;
    sample_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset:sample", sample, 32'd0);
    check("reset:valid", sample_valid, 32'd0);
    check("reset:cycle_done", cycle_done, 32'd0);
    check("reset:overrun", overrun, 32'd0);

    // Idle with reset released: step strobes are ignored
    rst_n   = 1'b1;
    step_en = 1'b1;
    tick("idle_step_ignored");
    step_en = 1'b0;

    // Sawtooth, 17 steps spaced 4 cycles apart
    prime("saw_prime");
    for (int i = 0; i < 17; i++) begin
      do_step($sformatf("saw_step%0d", i));
      for (int k = 0; k < 3; k++) tick($sformatf("saw_gap%0d_%0d", i, k));
    end

    // Triangle, phase_inc 64
    disable_gen("tri_dis");
    wave_sel  = 2'b10;
    phase_inc = 8'd64;
    prime("tri_prime");
    for (int i = 0; i < 4; i++) begin
      do_step($sformatf("tri_step%0d", i));
      tick($sformatf("tri_gap%0d", i));
    end

    // Square, phase_inc 128, then switch to DC between steps
    disable_gen("sq_dis");
    wave_sel  = 2'b00;
    phase_inc = 8'd128;
    prime("sq_prime");
    for (int i = 0; i < 3; i++) begin
      do_step($sformatf("sq_step%0d", i));
      tick($sformatf("sq_gap%0d", i));
    end
    wave_sel  = 2'b11;
    phase_inc = 8'd7;  // also changed between steps; must not matter until the step
    tick("dc_switch_hold0");
    tick("dc_switch_hold1");
    phase_inc = 8'd128;
    do_step("dc_step");
    tick("dc_gap");

    // Backpressure: overrun on the second unaccepted step
    disable_gen("bp_dis");
    wave_sel  = 2'b01;
    phase_inc = 8'd16;
    prime("bp_prime");
    tick("bp_consume_prime");
    sample_ready = 1'b0;
    do_step("bp_step0");
    tick("bp_hold0");
    tick("bp_hold1");
    do_step("bp_step1");
    tick("bp_hold2");
    sample_ready = 1'b1;
    tick("bp_transfer");
    tick("bp_after");
    tick("bp_sticky");
    disable_gen("bp_clear");

    // Step coincident with a transfer
    prime("co_prime");
    tick("co_consume_prime");
    do_step("co_step0");
    do_step("co_step1");
    tick("co_gap");

    // Asynchronous reset mid-run
    do_step("ar_step");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst:sample", sample, 32'd0);
    check("async_rst:valid", sample_valid, 32'd0);
    check("async_rst:cycle_done", cycle_done, 32'd0);
    check("async_rst:overrun", overrun, 32'd0);
    @(negedge clk);
    model_phase  = 0;
    model_sample = 0;
    model_valid  = 1'b0;
    model_ovr    = 1'b0;
    wave_sel     = 2'b11;
    prime("ar_prime");
    wave_sel = 2'b01;
    tick("ar_consume");
    do_step("ar_first_step");

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
